// File: rtl/motor_pkg.sv
// Shared types and constants for the motor command SPI receiver.
package motor_pkg;

    localparam int         FRAME_BITS       = 16;
    localparam logic [6:0] DEFAULT_MAX_DUTY = 7'd100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMMIT,
        ST_HOLD
    } state_t;

    typedef struct packed {
        logic       sign;
        logic [6:0] mag;
    } motor_cmd_t;

    // A motor field is {sign, magnitude}; magnitude is limited to the PWM period.
    function automatic motor_cmd_t decode_motor(input logic [7:0] field,
                                                input logic [6:0] max_duty);
        motor_cmd_t cmd;
        cmd.sign = field[7];
        cmd.mag  = (field[6:0] > max_duty) ? max_duty : field[6:0];
        return cmd;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for one asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronised copy.
module sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta   <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta   <= async_in;
            sync_q <= meta;
            prev_q <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~prev_q;
    assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/motor_cmd_rx.sv
// SPI slave that receives 16-bit two-motor duty commands, commits them with an
// active-low load strobe, echoes the last command on sdo and stops on silence.
module motor_cmd_rx
    import motor_pkg::*;
#(
    parameter logic [6:0]  MAX_DUTY    = DEFAULT_MAX_DUTY,
    parameter logic [23:0] WDOG_CYCLES = 24'd1_200_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       sdi,
    input  logic       cs_n,
    output logic       sdo,
    output logic       motor1_sign,
    output logic       motor2_sign,
    output logic [6:0] motor1_upperlimit,
    output logic [6:0] motor2_upperlimit,
    output logic       load,
    output logic       frame_err,
    output logic       wdog_tripped
);

    localparam logic [4:0] FULL_COUNT = 5'(FRAME_BITS);
    localparam logic [4:0] SAT_COUNT  = 5'(FRAME_BITS + 1);

    logic sck_sync, sck_rise, sck_fall;
    logic sdi_sync, sdi_rise, sdi_fall;
    logic cs_sync,  cs_rise,  cs_fall;
    logic unused_sync;

    logic [FRAME_BITS-1:0] rx_shift;
    logic [FRAME_BITS-1:0] tx_shift;
    logic [FRAME_BITS-1:0] last_frame;
    logic [4:0]            bit_cnt;
    logic [23:0]           wdog_cnt;
    state_t                state;
    logic                  hold_cnt;

    motor_cmd_t m1_next;
    motor_cmd_t m2_next;
    logic       commit_go;
    logic       wdog_expire;

    sync_edge #(.RESET_VAL(1'b0)) u_sync_sck (
        .clk      (clk),
        .reset    (reset),
        .async_in (sck),
        .sync_out (sck_sync),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    sync_edge #(.RESET_VAL(1'b0)) u_sync_sdi (
        .clk      (clk),
        .reset    (reset),
        .async_in (sdi),
        .sync_out (sdi_sync),
        .rise     (sdi_rise),
        .fall     (sdi_fall)
    );

    sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk      (clk),
        .reset    (reset),
        .async_in (cs_n),
        .sync_out (cs_sync),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    assign unused_sync = ^{sck_sync, sdi_rise, sdi_fall};

    // Shift path: rx samples on sck rise, tx advances on sck fall (SPI mode 0).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
        end else if (cs_fall) begin
            bit_cnt  <= '0;
            tx_shift <= last_frame;
        end else if (!cs_sync) begin
            if (sck_rise) begin
                rx_shift <= {rx_shift[FRAME_BITS-2:0], sdi_sync};
                bit_cnt  <= (bit_cnt == SAT_COUNT) ? SAT_COUNT : bit_cnt + 5'd1;
            end
            if (sck_fall) begin
                tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    assign sdo = ~cs_sync & tx_shift[FRAME_BITS-1];

    assign m1_next     = decode_motor(rx_shift[15:8], MAX_DUTY);
    assign m2_next     = decode_motor(rx_shift[7:0], MAX_DUTY);
    assign commit_go   = cs_rise && (state == ST_IDLE) && (bit_cnt == FULL_COUNT);
    assign wdog_expire = (state == ST_IDLE) && (wdog_cnt == WDOG_CYCLES - 24'd1);

    // Saturating at WDOG_CYCLES makes the expiry fire once per silent period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_cnt <= '0;
        end else if (state == ST_COMMIT) begin
            wdog_cnt <= '0;
        end else if (wdog_cnt != WDOG_CYCLES) begin
            wdog_cnt <= wdog_cnt + 24'd1;
        end
    end

    // Outputs change on entry to COMMIT so they are settled a cycle before load falls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= ST_IDLE;
            hold_cnt          <= 1'b0;
            load              <= 1'b1;
            frame_err         <= 1'b0;
            wdog_tripped      <= 1'b0;
            motor1_sign       <= 1'b0;
            motor2_sign       <= 1'b0;
            motor1_upperlimit <= '0;
            motor2_upperlimit <= '0;
            last_frame        <= '0;
        end else begin
            frame_err <= cs_rise && !commit_go;
            unique case (state)
                ST_IDLE: begin
                    if (commit_go) begin
                        state             <= ST_COMMIT;
                        motor1_sign       <= m1_next.sign;
                        motor1_upperlimit <= m1_next.mag;
                        motor2_sign       <= m2_next.sign;
                        motor2_upperlimit <= m2_next.mag;
                        last_frame        <= rx_shift;
                        wdog_tripped      <= 1'b0;
                    end else if (wdog_expire) begin
                        state             <= ST_HOLD;
                        hold_cnt          <= 1'b0;
                        load              <= 1'b0;
                        motor1_upperlimit <= '0;
                        motor2_upperlimit <= '0;
                        wdog_tripped      <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state    <= ST_HOLD;
                    hold_cnt <= 1'b0;
                    load     <= 1'b0;
                end
                ST_HOLD: begin
                    if (hold_cnt) begin
                        state <= ST_IDLE;
                        load  <= 1'b1;
                    end else begin
                        hold_cnt <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    load  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/motor_cmd_rx.md
MOTOR_CMD_RX -- requirements
Module: motor_cmd_rx

Interface
REQ-001 SHALL have parameter MAX_DUTY, default 7'd100, the magnitude clamp value, equal to the PWM counter period of the downstream motor controller.
REQ-002 SHALL have parameter WDOG_CYCLES, default 24'd1_200_000, the clk cycles without a valid frame before a safety stop (100 ms at 12 MHz).
REQ-003 SHALL have port clk  input  1  the single system clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sck  input  1  SPI clock from the MCU, mode 0, asynchronous to clk.
REQ-006 SHALL have port sdi  input  1  SPI data from the MCU, MSB first.
REQ-007 SHALL have port cs_n  input  1  SPI chip select, active-low, frames one command.
REQ-008 SHALL have port sdo  output  1  SPI echo data to the MCU.
REQ-009 SHALL have ports motor1_sign / motor2_sign  output  1 each  motor direction.
REQ-010 SHALL have ports motor1_upperlimit / motor2_upperlimit  output  7 each  duty magnitude, 0..MAX_DUTY.
REQ-011 SHALL have port load  output  1  active-low commit strobe; the consumer captures the magnitudes while it is low.
REQ-012 SHALL have port frame_err  output  1  one-clk pulse on a malformed frame.
REQ-013 SHALL have port wdog_tripped  output  1  sticky flag, set by a watchdog stop.

Function
REQ-014 SHALL synchronise sck, sdi and cs_n through 2 flops each and detect sck rise/fall and cs_n rise/fall on the synchronised copies.
REQ-015 SHALL, on a cs_n fall, clear the 5-bit bit counter and load the tx shift register with the last committed 16-bit frame.
REQ-016 SHALL, on each sck rise while cs_n is low, shift sdi into a 16-bit rx register MSB first and increment the bit counter, saturating at 17.
REQ-017 SHALL, on each sck fall while cs_n is low, shift the tx register; sdo = tx[15] while cs_n is low, and sdo = 0 while cs_n is high.
REQ-018 SHALL decode the frame as: bit 15 = motor1_sign, bits 14:8 = motor1 magnitude, bit 7 = motor2_sign, bits 6:0 = motor2 magnitude.
REQ-019 SHALL clamp each magnitude: a value > MAX_DUTY is output as MAX_DUTY.
REQ-020 SHALL implement an FSM with states IDLE, COMMIT and HOLD.
- IDLE -> COMMIT on cs_n rise with count == 16.
- IDLE -> HOLD on watchdog expiry.
- COMMIT -> HOLD after exactly 1 cycle.
- HOLD -> IDLE after exactly 2 cycles.
REQ-021 SHALL, on cs_n rise with count != 16, pulse frame_err for 1 clk and leave the outputs, load and the FSM unchanged.
REQ-022 SHALL register the decoded outputs on the COMMIT cycle; load = 0 only in HOLD, so the outputs are stable before load falls.
REQ-023 SHALL update the outputs no later than 4 clk after the cs_n pin rises; load SHALL then be low for exactly the 2 following clk.
REQ-024 SHALL run a watchdog counter that clears on COMMIT and otherwise increments, saturating.
REQ-025 SHALL, when the watchdog counter reaches WDOG_CYCLES-1, force both magnitudes to 0 (signs unchanged), set wdog_tripped and enter HOLD.
REQ-026 SHALL clear wdog_tripped on the next COMMIT.
REQ-027 SHALL give COMMIT priority when COMMIT and watchdog expiry coincide.
REQ-028 SHALL ignore a cs_n rise arriving during COMMIT/HOLD for commit purposes, and flag it as a frame_err pulse.

Reset
REQ-029 SHALL, while reset = 0:
- motor1/2_sign = 0, motor1/2_upperlimit = 0
- load = 1, sdo = 0, frame_err = 0, wdog_tripped = 0
- FSM = IDLE; all counters, shift registers and synchronisers = 0, except the cs_n synchroniser = 1.
REQ-030 SHALL, on a reset assertion mid-frame, discard the partial frame and produce no commit after release.

Structure
REQ-031 SHALL take the state enum, FRAME_BITS = 16, the default MAX_DUTY constant and the motor_cmd_t struct {sign, mag[6:0]} from a shared package motor_pkg.
REQ-032 SHALL instantiate one sub-module sync_edge (2-flop synchroniser plus rise/fall pulse outputs) per asynchronous input.

Verification
REQ-033 SHALL cover: frame 0x8A32 -> motor1 = {1,10}, motor2 = {0,50}, load low 2 clk within 6 clk of the cs_n rise, frame_err = 0.
REQ-034 SHALL cover: frame 0xFF7F -> both magnitudes = 100, motor1_sign = 1, motor2_sign = 0.
REQ-035 SHALL cover: a 12-bit frame, then a 17-bit frame -> a frame_err pulse each time, outputs unchanged, load stays high.
REQ-036 SHALL cover, with WDOG_CYCLES = 1000, no frame for 1000 clk -> magnitudes 0, wdog_tripped = 1, load low 2 clk; the next valid frame clears wdog_tripped.
REQ-037 SHALL cover: frame 0x8A32 committed, then the next frame -> sdo streams 0x8A32 MSB first.
REQ-038 SHALL cover: reset asserted after 8 bits of 0x1234, then a full 0x0505 frame -> only 0x0505 commits.
